// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: definitions shared by the data-memory arbiter and the memory.
//   - size codes carried on cpu_size / dma_size / mem_store / mem_load
//   - arbiter FSM state encoding
//   - port indices for the per-port alignment checkers
//   - align_ok(): size/alignment legality rule, also usable by the dmem itself
package dmem_arb_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int NUM_PORTS = 2;
    localparam int PORT_CPU  = 0;
    localparam int PORT_DMA  = 1;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_DACK = 1'b1
    } arb_state_t;

    // Word accesses need addr[1:0]==00, halves need addr[0]==0, bytes
    // are always fine and the reserved size code is never legal.
    function automatic logic align_ok(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_WORD: ok = (addr_lo == 2'b00);
            SZ_HALF: ok = ~addr_lo[0];
            SZ_BYTE: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_align_chk.sv
// dmem_align_chk: size/alignment legality check for one requester port.
//   size    in  2  access size code (word/half/byte/illegal)
//   addr_lo in  2  low two bits of the byte address
//   ok      out 1  access is legal
module dmem_align_chk
    import dmem_arb_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic       ok
);

    assign ok = align_ok(size, addr_lo);

endmodule

// File: rtl/dmem_arb.sv
// dmem_arb: two-port arbiter in front of the single-ported data memory.
// The CPU (MEM stage) has fixed priority; the DMA/loader port is forced
// through after MAX_HOLD consecutive conflict cycles lost to the CPU.
//   clk, reset                      clock, async active-high reset
//   cpu_req/we/size/addr/wdata      CPU request (zero-latency access)
//   cpu_rdata                       load data when CPU granted, else 0
//   cpu_stall                       CPU requested but lost arbitration
//   cpu_misalign                    granted CPU access is illegal
//   dma_req/we/size/addr/wdata      DMA request, held until dma_ack
//   dma_ack, dma_rdata, dma_err     registered completion, data, error
//   mem_wr/store/load/addr/wdata    drive to dmem; mem_rdata comes back
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_misalign,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [1:0]  dma_size,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_err,
    output logic        mem_wr,
    output logic [1:0]  mem_store,
    output logic [1:0]  mem_load,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    arb_state_t  state_reg, state_next;
    logic [3:0]  hold_cnt_reg, hold_cnt_next;
    logic [31:0] dma_rdata_reg;
    logic        dma_err_reg;
    logic        cpu_grant, dma_grant;

    // Per-port legality checks.
    logic [1:0] chk_size    [NUM_PORTS];
    logic [1:0] chk_addr_lo [NUM_PORTS];
    logic       chk_ok      [NUM_PORTS];

    assign chk_size[PORT_CPU]    = cpu_size;
    assign chk_addr_lo[PORT_CPU] = cpu_addr[1:0];
    assign chk_size[PORT_DMA]    = dma_size;
    assign chk_addr_lo[PORT_DMA] = dma_addr[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_chk
            dmem_align_chk u_chk (
                .size    (chk_size[gi]),
                .addr_lo (chk_addr_lo[gi]),
                .ok      (chk_ok[gi])
            );
        end
    endgenerate

    // Next-state / grant logic.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        cpu_grant     = 1'b0;
        dma_grant     = 1'b0;
        case (state_reg)
            ST_ARB: begin
                if (dma_req && (!cpu_req || hold_cnt_reg == HOLD_MAX)) begin
                    dma_grant  = 1'b1;
                    state_next = ST_DACK;
                end else begin
                    cpu_grant = cpu_req;
                end
                // Reaching the increment branch implies a conflict the CPU
                // won, and the count is below the limit.
                if (dma_grant || !dma_req) begin
                    hold_cnt_next = 4'd0;
                end else if (hold_cnt_reg != HOLD_MAX) begin
                    hold_cnt_next = hold_cnt_reg + 4'd1;
                end
            end
            ST_DACK: begin
                // The DMA request is still high while it is acknowledged,
                // so it must not be re-granted here.
                cpu_grant  = cpu_req;
                state_next = ST_ARB;
                if (!dma_req) begin
                    hold_cnt_next = 4'd0;
                end
            end
            default: begin
                state_next = ST_ARB;
            end
        endcase
    end

    // Memory-side mux; with no grant the CPU fields are passed through
    // so the address path does not toggle needlessly.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_store = cpu_size;
        mem_load  = cpu_size;
        mem_wr    = 1'b0;
        if (dma_grant) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_store = dma_size;
            mem_load  = dma_size;
            mem_wr    = dma_we && chk_ok[PORT_DMA];
        end else if (cpu_grant) begin
            mem_wr    = cpu_we && chk_ok[PORT_CPU];
        end
    end

    assign cpu_stall    = cpu_req && !cpu_grant;
    assign cpu_misalign = cpu_grant && !chk_ok[PORT_CPU];
    assign cpu_rdata    = cpu_grant ? mem_rdata : 32'd0;
    assign dma_ack      = (state_reg == ST_DACK);
    assign dma_rdata    = dma_rdata_reg;
    assign dma_err      = dma_err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_ARB;
            hold_cnt_reg  <= 4'd0;
            dma_rdata_reg <= 32'd0;
            dma_err_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            if (dma_grant) begin
                dma_rdata_reg <= mem_rdata;
                dma_err_reg   <= !chk_ok[PORT_DMA];
            end
        end
    end

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed scenarios plus randomized traffic for dmem_arb,
// with a byte-array reference memory and spec-level arbitration model.
module tb_dmem_arb;

    localparam int MAX_HOLD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, cpu_misalign;
    logic        dma_req, dma_we;
    logic [1:0]  dma_size;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ack, dma_err;
    logic        mem_wr;
    logic [1:0]  mem_store, mem_load;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dmem_arb #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_we       (cpu_we),
        .cpu_size     (cpu_size),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .cpu_misalign (cpu_misalign),
        .dma_req      (dma_req),
        .dma_we       (dma_we),
        .dma_size     (dma_size),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .dma_ack      (dma_ack),
        .dma_rdata    (dma_rdata),
        .dma_err      (dma_err),
        .mem_wr       (mem_wr),
        .mem_store    (mem_store),
        .mem_load     (mem_load),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // Data memory: 1 KiB, lane-aware stores, sign-extending loads.
    logic [31:0] mem_words [0:255] = '{default: 32'd0};
    logic [31:0] word_rd, word_sh;

    always_comb begin
        word_rd = mem_words[mem_addr[9:2]];
        word_sh = 32'd0;
        case (mem_load)
            2'b01: begin
                word_sh   = word_rd >> {mem_addr[1], 4'b0000};
                mem_rdata = {{16{word_sh[15]}}, word_sh[15:0]};
            end
            2'b10: begin
                word_sh   = word_rd >> {mem_addr[1:0], 3'b000};
                mem_rdata = {{24{word_sh[7]}}, word_sh[7:0]};
            end
            default: mem_rdata = word_rd;
        endcase
    end

    always @(posedge clk) begin
        if (mem_wr) begin
            case (mem_store)
                2'b00: mem_words[mem_addr[9:2]] <= mem_wdata;
                2'b01: mem_words[mem_addr[9:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
                2'b10: mem_words[mem_addr[9:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
                default: ;
            endcase
        end
    end

    // Reference model: flat byte array, little-endian.
    logic [7:0] ref_mem [0:1023];

    function automatic bit ref_ok(input logic [1:0] size, input logic [31:0] addr);
        case (size)
            2'b00:   return (addr % 4) == 0;
            2'b01:   return (addr % 2) == 0;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int ref_nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] v = 32'd0;
        int n = ref_nbytes(size);
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[10'(addr + 32'(k))]) << (8 * k));
        if (n == 2 && v[15]) v = v | 32'hFFFF_0000;
        if (n == 1 && v[7])  v = v | 32'hFFFF_FF00;
        return v;
    endfunction

    function automatic void ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        int n = ref_nbytes(size);
        for (int k = 0; k < n; k++) ref_mem[10'(addr + 32'(k))] = 8'(data >> (8 * k));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dma_req = 1'b0; dma_we = 1'b0; dma_size = 2'b00; dma_addr = 32'd0; dma_wdata = 32'd0;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({dma_ack, dma_err, mem_wr, cpu_stall} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: ack/err/wr/stall got %b expected 0000", {dma_ack, dma_err, mem_wr, cpu_stall});
        end
        tests_run++;
        if (dma_rdata !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h expected 00000000", dma_rdata);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("[TB] reset released");
    endtask

    task automatic test_cpu_word();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b00; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tests_run++;
        if ({cpu_stall, mem_wr, cpu_misalign} !== 3'b010) begin
            tests_failed++;
            $display("FAIL cpu_store: stall/wr/misalign got %b expected 010", {cpu_stall, mem_wr, cpu_misalign});
        end
        tick();
        ref_store(2'b00, 32'h10, 32'hDEAD_BEEF);
        cpu_we = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cpu_rdata !== 32'hDEAD_BEEF || mem_wr !== 1'b0 || cpu_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL cpu_load: rdata %h wr %b stall %b expected deadbeef 0 0", cpu_rdata, mem_wr, cpu_stall);
        end
        $display("[TB] cpu word store/load @0x10 rdata=%h", cpu_rdata);
        tick();
        idle_inputs();
    endtask

    task automatic test_dma_byte();
        dma_req = 1'b1; dma_we = 1'b1; dma_size = 2'b10; dma_addr = 32'h21; dma_wdata = 32'h80;
        @(negedge clk);
        tests_run++;
        if (mem_wr !== 1'b1 || mem_addr !== 32'h21 || dma_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL dma_grant: wr %b addr %h ack %b expected 1 00000021 0", mem_wr, mem_addr, dma_ack);
        end
        tick();
        ref_store(2'b10, 32'h21, 32'h80);
        @(negedge clk);
        tests_run++;
        if (dma_ack !== 1'b1 || mem_wr !== 1'b0 || dma_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL dma_ack: ack %b wr %b err %b expected 1 0 0", dma_ack, mem_wr, dma_err);
        end
        tick();
        // Back-to-back: the next request is granted in cycle N+2.
        dma_we = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dma_ack !== 1'b0 || mem_addr !== 32'h21 || mem_load !== 2'b10) begin
            tests_failed++;
            $display("FAIL dma_b2b_grant: ack %b addr %h load %b expected 0 00000021 10", dma_ack, mem_addr, mem_load);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (dma_ack !== 1'b1 || dma_rdata !== ref_load(2'b10, 32'h21)) begin
            tests_failed++;
            $display("FAIL dma_byte_load: ack %b rdata %h expected 1 %h", dma_ack, dma_rdata, ref_load(2'b10, 32'h21));
        end
        $display("[TB] dma byte store/load @0x21 rdata=%h", dma_rdata);
        tick();
        idle_inputs();
    endtask

    task automatic test_starvation();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_we = 1'b0; dma_size = 2'b00; dma_addr = 32'h20;
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < MAX_HOLD; i++) begin
                @(negedge clk);
                tests_run++;
                if (cpu_stall !== 1'b0 || mem_addr !== 32'h10) begin
                    tests_failed++;
                    $display("FAIL starve_cpu_win r%0d c%0d: stall %b addr %h expected 0 00000010", round, i, cpu_stall, mem_addr);
                end
                tick();
            end
            @(negedge clk);
            tests_run++;
            if (cpu_stall !== 1'b1 || mem_addr !== 32'h20) begin
                tests_failed++;
                $display("FAIL starve_dma_forced r%0d: stall %b addr %h expected 1 00000020", round, cpu_stall, mem_addr);
            end
            tick();
            @(negedge clk);
            tests_run++;
            if (dma_ack !== 1'b1 || cpu_stall !== 1'b0 || dma_rdata !== ref_load(2'b00, 32'h20)) begin
                tests_failed++;
                $display("FAIL starve_ack r%0d: ack %b stall %b rdata %h expected 1 0 %h", round, dma_ack, cpu_stall, dma_rdata, ref_load(2'b00, 32'h20));
            end
            $display("[TB] starvation round %0d: dma forced after %0d cpu wins", round, MAX_HOLD);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_misalign();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = 2'b01; cpu_addr = 32'h03; cpu_wdata = 32'h1234;
        @(negedge clk);
        tests_run++;
        if ({cpu_misalign, mem_wr, cpu_stall} !== 3'b100) begin
            tests_failed++;
            $display("FAIL cpu_misalign: misalign/wr/stall got %b expected 100", {cpu_misalign, mem_wr, cpu_stall});
        end
        tick();
        cpu_we = 1'b0; cpu_size = 2'b00; cpu_addr = 32'h00;
        @(negedge clk);
        tests_run++;
        if (cpu_rdata !== ref_load(2'b00, 32'h00) || cpu_misalign !== 1'b0) begin
            tests_failed++;
            $display("FAIL misalign_unchanged: rdata %h misalign %b expected %h 0", cpu_rdata, cpu_misalign, ref_load(2'b00, 32'h00));
        end
        $display("[TB] cpu half store @0x03 rejected, word @0x00=%h", cpu_rdata);
        tick();
        idle_inputs();
        dma_req = 1'b1; dma_we = 1'b1; dma_size = 2'b11; dma_addr = 32'h40; dma_wdata = 32'hFF;
        @(negedge clk);
        tests_run++;
        if (mem_wr !== 1'b0 || mem_addr !== 32'h40) begin
            tests_failed++;
            $display("FAIL dma_illegal_grant: wr %b addr %h expected 0 00000040", mem_wr, mem_addr);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (dma_ack !== 1'b1 || dma_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL dma_err: ack %b err %b expected 1 1", dma_ack, dma_err);
        end
        $display("[TB] dma size 11 @0x40 err=%b", dma_err);
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_dack();
        dma_req = 1'b1; dma_we = 1'b0; dma_size = 2'b00; dma_addr = 32'h10;
        tick();
        tests_run++;
        if (dma_ack !== 1'b1 || dma_rdata !== ref_load(2'b00, 32'h10)) begin
            tests_failed++;
            $display("FAIL pre_reset_ack: ack %b rdata %h expected 1 %h", dma_ack, dma_rdata, ref_load(2'b00, 32'h10));
        end
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (dma_ack !== 1'b0 || dma_rdata !== 32'd0 || dma_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: ack %b rdata %h err %b expected 0 00000000 0", dma_ack, dma_rdata, dma_err);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (dma_ack !== 1'b0 || mem_addr !== 32'h10 || cpu_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL reissue_grant: ack %b addr %h stall %b expected 0 00000010 0", dma_ack, mem_addr, cpu_stall);
        end
        tick();
        @(negedge clk);
        tests_run++;
        if (dma_ack !== 1'b1 || dma_rdata !== ref_load(2'b00, 32'h10)) begin
            tests_failed++;
            $display("FAIL reissue_ack: ack %b rdata %h expected 1 %h", dma_ack, dma_rdata, ref_load(2'b00, 32'h10));
        end
        $display("[TB] dma reissued after reset in ack cycle, rdata=%h", dma_rdata);
        tick();
        idle_inputs();
        // Build up a partial hold count, reset, and expect a full MAX_HOLD again.
        cpu_req = 1'b1; cpu_addr = 32'h10;
        dma_req = 1'b1; dma_addr = 32'h20;
        tick();
        tick();
        #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < MAX_HOLD; i++) begin
            @(negedge clk);
            tests_run++;
            if (cpu_stall !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_after_reset c%0d: stall %b expected 0", i, cpu_stall);
            end
            tick();
        end
        @(negedge clk);
        tests_run++;
        if (cpu_stall !== 1'b1 || mem_addr !== 32'h20) begin
            tests_failed++;
            $display("FAIL hold_after_reset_forced: stall %b addr %h expected 1 00000020", cpu_stall, mem_addr);
        end
        $display("[TB] hold count restarted from 0 after reset");
        tick();
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit          ack_due  = 1'b0;
        bit          dma_done = 1'b0;
        int          wait_cnt = 0;
        bit          last_ok  = 1'b0;
        bit          last_ld  = 1'b0;
        logic [31:0] last_exp = 32'd0;
        bit          exp_dg, exp_cg, exp_wr, cpu_ok, dma_ok;
        int          acks = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            cpu_req   = ($urandom_range(0, 99) < 60);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            cpu_addr  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0)
                cpu_addr = cpu_addr & ~32'(ref_nbytes(cpu_size) - 1);
            cpu_wdata = $urandom;
            if (!dma_req || dma_done) begin
                dma_done  = 1'b0;
                dma_req   = ($urandom_range(0, 99) < 40);
                dma_we    = 1'($urandom_range(0, 1));
                dma_size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                dma_addr  = 32'($urandom_range(0, 1023));
                if ($urandom_range(0, 3) != 0)
                    dma_addr = dma_addr & ~32'(ref_nbytes(dma_size) - 1);
                dma_wdata = $urandom;
            end
            cpu_ok = ref_ok(cpu_size, cpu_addr);
            dma_ok = ref_ok(dma_size, dma_addr);
            exp_dg = !ack_due && dma_req && (!cpu_req || wait_cnt == MAX_HOLD);
            exp_cg = cpu_req && !exp_dg;
            exp_wr = (exp_dg && dma_we && dma_ok) || (exp_cg && cpu_we && cpu_ok);
            @(negedge clk);
            tests_run++;
            if ({cpu_stall, mem_wr, cpu_misalign, dma_ack} !== {cpu_req && !exp_cg, exp_wr, exp_cg && !cpu_ok, ack_due}) begin
                tests_failed++;
                $display("FAIL rand_ctrl cyc%0d: stall/wr/mis/ack got %b expected %b", cyc,
                         {cpu_stall, mem_wr, cpu_misalign, dma_ack}, {cpu_req && !exp_cg, exp_wr, exp_cg && !cpu_ok, ack_due});
            end
            tests_run++;
            if (mem_addr !== (exp_dg ? dma_addr : cpu_addr)) begin
                tests_failed++;
                $display("FAIL rand_addr cyc%0d: got %h expected %h", cyc, mem_addr, exp_dg ? dma_addr : cpu_addr);
            end
            if (!exp_cg || (!cpu_we && cpu_ok)) begin
                tests_run++;
                if (cpu_rdata !== (exp_cg ? ref_load(cpu_size, cpu_addr) : 32'd0)) begin
                    tests_failed++;
                    $display("FAIL rand_cpu_rdata cyc%0d: got %h expected %h", cyc, cpu_rdata,
                             exp_cg ? ref_load(cpu_size, cpu_addr) : 32'd0);
                end
            end
            if (ack_due) begin
                acks++;
                tests_run++;
                if (dma_err !== !last_ok || (last_ld && last_ok && dma_rdata !== last_exp)) begin
                    tests_failed++;
                    $display("FAIL rand_dma_done cyc%0d: err %b rdata %h expected %b %h", cyc, dma_err, dma_rdata, !last_ok, last_exp);
                end
                $display("[TB] rand dma #%0d done cyc%0d err=%b rdata=%h", acks, cyc, dma_err, dma_rdata);
                dma_done = 1'b1;
            end
            if (exp_dg) begin
                last_ok  = dma_ok;
                last_ld  = !dma_we;
                last_exp = ref_load(dma_size, dma_addr);
                if (dma_we && dma_ok) ref_store(dma_size, dma_addr, dma_wdata);
            end
            if (exp_cg && cpu_we && cpu_ok) ref_store(cpu_size, cpu_addr, cpu_wdata);
            if (exp_dg || !dma_req)              wait_cnt = 0;
            else if (!ack_due && cpu_req && wait_cnt < MAX_HOLD) wait_cnt++;
            ack_due = exp_dg;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'd0;
        test_reset();
        test_cpu_word();
        test_dma_byte();
        test_starvation();
        test_misalign();
        test_reset_dack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
